bip3_core: RTL and testbench

Single-cycle accumulator processor, successor to the BIP2 core: same Harvard memory interface (combinational instruction and data reads, one data write strobe), but with independently parametrised data and address widths. It adds a Z/N status register with the full signed branch set, logic and shift instructions, and a sticky halt state. It sits between the instruction ROM and the data RAM at the top of the CPU subsystem.

---
 rtl/bip3_core_if.sv | 25 ++
 rtl/bip3_core.sv | 134 +++++++++++++
 tb/tb_bip3_core.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/bip3_core_if.sv
// Harvard memory bus between bip3_core and its instruction ROM / data RAM.
// Latency: none, wires only; reads are combinational, the write lands on the next clock edge.
// Backpressure: none; the ROM and RAM must answer in the same cycle.
interface bip3_core_if #(
    parameter int OPERAND_ADDRESS_WIDTH = 11,
    parameter int DATA_WIDTH            = 16
);
    logic [OPERAND_ADDRESS_WIDTH+4:0] instruction_in;
    logic [DATA_WIDTH-1:0]            data_in;
    logic [OPERAND_ADDRESS_WIDTH-1:0] instruction_address_out;
    logic [OPERAND_ADDRESS_WIDTH-1:0] data_address_out;
    logic [DATA_WIDTH-1:0]            data_out;
    logic                             data_wr_out;
    logic                             halted_out;

    modport master (
        input  instruction_in, data_in,
        output instruction_address_out, data_address_out, data_out, data_wr_out, halted_out
    );

    modport slave (
        output instruction_in, data_in,
        input  instruction_address_out, data_address_out, data_out, data_wr_out, halted_out
    );
endinterface

// File: rtl/bip3_core.sv
// Single-cycle accumulator CPU with Z/N flags, signed branches and sticky halt; BIP3_LOGIC_EN adds NOT/AND/OR/XOR/SLL/SRL.
// Latency: one instruction per clock; PC, ACC, flags and halt update on the edge ending the cycle.
// Backpressure: none; the core never stalls, and a halted core freezes until reset.
module bip3_core #(
    parameter int OPERAND_ADDRESS_WIDTH = 11,
    parameter int DATA_WIDTH            = 16
) (
    input  logic      clock_in,
    input  logic      reset_in,
    bip3_core_if.master bus
);
    localparam int AW = OPERAND_ADDRESS_WIDTH;
    localparam int DW = DATA_WIDTH;

    localparam logic [4:0] OP_HLT  = 5'b00000;
    localparam logic [4:0] OP_STO  = 5'b00001;
    localparam logic [4:0] OP_LD   = 5'b00010;
    localparam logic [4:0] OP_LDI  = 5'b00011;
    localparam logic [4:0] OP_ADD  = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_SUB  = 5'b00110;
    localparam logic [4:0] OP_SUBI = 5'b00111;
    localparam logic [4:0] OP_BEQ  = 5'b01000;
    localparam logic [4:0] OP_BNE  = 5'b01001;
    localparam logic [4:0] OP_BGT  = 5'b01010;
    localparam logic [4:0] OP_BGE  = 5'b01011;
    localparam logic [4:0] OP_BLT  = 5'b01100;
    localparam logic [4:0] OP_BLE  = 5'b01101;
    localparam logic [4:0] OP_JMP  = 5'b01110;
`ifdef BIP3_LOGIC_EN
    localparam logic [4:0] OP_NOT  = 5'b01111;
    localparam logic [4:0] OP_AND  = 5'b10000;
    localparam logic [4:0] OP_ANDI = 5'b10001;
    localparam logic [4:0] OP_OR   = 5'b10010;
    localparam logic [4:0] OP_ORI  = 5'b10011;
    localparam logic [4:0] OP_XOR  = 5'b10100;
    localparam logic [4:0] OP_XORI = 5'b10101;
    localparam logic [4:0] OP_SLL  = 5'b10110;
    localparam logic [4:0] OP_SRL  = 5'b10111;
    localparam int         SW      = $clog2(DW);
    logic [SW-1:0] shamt;
`endif

    logic [AW-1:0] pc_q, pc_d;
    logic [DW-1:0] acc_q, acc_d;
    logic          z_q, z_d, n_q, n_d, halt_q, halt_d;
    logic [4:0]    opcode;
    logic [AW-1:0] operand;
    logic [DW-1:0] imm, mem;
    logic          flags_upd, taken, wr;

    assign opcode  = bus.instruction_in[AW+4 -: 5];
    assign operand = bus.instruction_in[AW-1:0];
    assign imm     = DW'($signed(operand));
    assign mem     = bus.data_in;
`ifdef BIP3_LOGIC_EN
    assign shamt   = operand[SW-1:0];
`endif

    always_comb begin
        acc_d     = acc_q;
        pc_d      = pc_q + AW'(1);
        z_d       = z_q;
        n_d       = n_q;
        halt_d    = halt_q;
        flags_upd = 1'b0;
        taken     = 1'b0;
        wr        = 1'b0;
        case (opcode)
            OP_HLT:  begin halt_d = 1'b1; pc_d = pc_q; end
            OP_STO:  wr = 1'b1;
            OP_LD:   acc_d = mem;
            OP_LDI:  acc_d = imm;
            OP_ADD:  begin acc_d = acc_q + mem; flags_upd = 1'b1; end
            OP_ADDI: begin acc_d = acc_q + imm; flags_upd = 1'b1; end
            OP_SUB:  begin acc_d = acc_q - mem; flags_upd = 1'b1; end
            OP_SUBI: begin acc_d = acc_q - imm; flags_upd = 1'b1; end
            OP_BEQ:  taken = z_q;
            OP_BNE:  taken = !z_q;
            OP_BGT:  taken = !z_q && !n_q;
            OP_BGE:  taken = !n_q;
            OP_BLT:  taken = n_q;
            OP_BLE:  taken = n_q || z_q;
            OP_JMP:  taken = 1'b1;
`ifdef BIP3_LOGIC_EN
            OP_NOT:  begin acc_d = ~acc_q;        flags_upd = 1'b1; end
            OP_AND:  begin acc_d = acc_q & mem;   flags_upd = 1'b1; end
            OP_ANDI: begin acc_d = acc_q & imm;   flags_upd = 1'b1; end
            OP_OR:   begin acc_d = acc_q | mem;   flags_upd = 1'b1; end
            OP_ORI:  begin acc_d = acc_q | imm;   flags_upd = 1'b1; end
            OP_XOR:  begin acc_d = acc_q ^ mem;   flags_upd = 1'b1; end
            OP_XORI: begin acc_d = acc_q ^ imm;   flags_upd = 1'b1; end
            OP_SLL:  begin acc_d = acc_q << shamt; flags_upd = 1'b1; end
            OP_SRL:  begin acc_d = acc_q >> shamt; flags_upd = 1'b1; end
`endif
            default: ;
        endcase
        if (taken) pc_d = operand;
        if (flags_upd) begin
            z_d = (acc_d == '0);
            n_d = acc_d[DW-1];
        end
        // A halted core ignores the instruction bus entirely.
        if (halt_q) begin
            pc_d  = pc_q;
            acc_d = acc_q;
            z_d   = z_q;
            n_d   = n_q;
            wr    = 1'b0;
        end
    end

    always_ff @(posedge clock_in) begin
        if (!reset_in) begin
            pc_q   <= '0;
            acc_q  <= '0;
            z_q    <= 1'b0;
            n_q    <= 1'b0;
            halt_q <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            acc_q  <= acc_d;
            z_q    <= z_d;
            n_q    <= n_d;
            halt_q <= halt_d;
        end
    end

    assign bus.instruction_address_out = pc_q;
    assign bus.data_address_out        = operand;
    assign bus.data_out                = acc_q;
    assign bus.data_wr_out             = wr && reset_in;
    assign bus.halted_out              = halt_q;
endmodule

// File: tb/tb_bip3_core.sv
// Directed-vector bench for bip3_core: table of instructions with hand-computed PC/ACC/strobe/halt,
// plus hand sequences for reset, halt release, PC wrap and (when built with it) the logic/shift opcodes.
module tb_bip3_core;
    localparam logic [4:0] HLT = 5'b00000, STO = 5'b00001, LD = 5'b00010, LDI = 5'b00011;
    localparam logic [4:0] ADD = 5'b00100, ADDI = 5'b00101, SUB = 5'b00110, SUBI = 5'b00111;
    localparam logic [4:0] BEQ = 5'b01000, BNE = 5'b01001, BGT = 5'b01010, BGE = 5'b01011;
    localparam logic [4:0] BLT = 5'b01100, BLE = 5'b01101, JMP = 5'b01110, NOT = 5'b01111;
    localparam logic [4:0] AND = 5'b10000, ANDI = 5'b10001, OR = 5'b10010, ORI = 5'b10011;
    localparam logic [4:0] XOR = 5'b10100, XORI = 5'b10101, SLL = 5'b10110, SRL = 5'b10111;
    localparam logic [4:0] NOP = 5'b11000;
`ifdef BIP3_LOGIC_EN
    localparam logic [15:0] X_ACC = 16'hFFFC;
`else
    localparam logic [15:0] X_ACC = 16'hFFFF;
`endif

    typedef struct {
        logic [15:0] instr;
        logic [15:0] din;
        logic        exp_wr;
        logic [10:0] exp_pc;
        logic [15:0] exp_acc;
        logic        exp_halt;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    vec_t vt [29];

    always #5 clk = ~clk;

    bip3_core_if #(.OPERAND_ADDRESS_WIDTH(11), .DATA_WIDTH(16)) bus ();

    bip3_core #(.OPERAND_ADDRESS_WIDTH(11), .DATA_WIDTH(16)) dut (
        .clock_in (clk),
        .reset_in (rst_n),
        .bus      (bus)
    );

    function automatic logic [15:0] ins(input logic [4:0] op, input logic [10:0] opd);
        return {op, opd};
    endfunction

    function automatic vec_t mk(input logic [4:0] op, input logic [10:0] opd, input logic [15:0] din,
                                input logic wr, input logic [10:0] pc, input logic [15:0] acc,
                                input logic halt);
        vec_t v;
        v.instr = ins(op, opd); v.din = din; v.exp_wr = wr;
        v.exp_pc = pc; v.exp_acc = acc; v.exp_halt = halt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic apply(input vec_t v, input string tag);
        bus.instruction_in = v.instr;
        bus.data_in        = v.din;
        #1;
        chk({tag, ".wr"}, 32'(bus.data_wr_out), 32'(v.exp_wr));
        chk({tag, ".daddr"}, 32'(bus.data_address_out), 32'(v.instr[10:0]));
        @(posedge clk);
        #1;
        chk({tag, ".pc"}, 32'(bus.instruction_address_out), 32'(v.exp_pc));
        chk({tag, ".acc"}, 32'(bus.data_out), 32'(v.exp_acc));
        chk({tag, ".halt"}, 32'(bus.halted_out), 32'(v.exp_halt));
        @(negedge clk);
    endtask

    initial begin
        vt[0]  = mk(LDI,  11'h005, 16'h0000, 0, 11'h001, 16'h0005, 0);
        vt[1]  = mk(ADDI, 11'h7F9, 16'h0000, 0, 11'h002, 16'hFFFE, 0);
        vt[2]  = mk(BLT,  11'h020, 16'h0000, 0, 11'h020, 16'hFFFE, 0);
        vt[3]  = mk(BGE,  11'h040, 16'h0000, 0, 11'h021, 16'hFFFE, 0);
        vt[4]  = mk(BGT,  11'h050, 16'h0000, 0, 11'h022, 16'hFFFE, 0);
        vt[5]  = mk(BLE,  11'h060, 16'h0000, 0, 11'h060, 16'hFFFE, 0);
        vt[6]  = mk(LDI,  11'h005, 16'h0000, 0, 11'h061, 16'h0005, 0);
        vt[7]  = mk(BLT,  11'h070, 16'h0000, 0, 11'h070, 16'h0005, 0);
        vt[8]  = mk(SUBI, 11'h005, 16'h0000, 0, 11'h071, 16'h0000, 0);
        vt[9]  = mk(BEQ,  11'h100, 16'h0000, 0, 11'h100, 16'h0000, 0);
        vt[10] = mk(LDI,  11'h003, 16'h0000, 0, 11'h101, 16'h0003, 0);
        vt[11] = mk(BNE,  11'h200, 16'h0000, 0, 11'h102, 16'h0003, 0);
        vt[12] = mk(BGE,  11'h300, 16'h0000, 0, 11'h300, 16'h0003, 0);
        vt[13] = mk(BGT,  11'h010, 16'h0000, 0, 11'h301, 16'h0003, 0);
        vt[14] = mk(LD,   11'h003, 16'h1234, 0, 11'h302, 16'h1234, 0);
        vt[15] = mk(BEQ,  11'h400, 16'h0000, 0, 11'h400, 16'h1234, 0);
        vt[16] = mk(STO,  11'h005, 16'h5555, 1, 11'h401, 16'h1234, 0);
        vt[17] = mk(LD,   11'h007, 16'hBEEF, 0, 11'h402, 16'hBEEF, 0);
        vt[18] = mk(BEQ,  11'h410, 16'h0000, 0, 11'h410, 16'hBEEF, 0);
        vt[19] = mk(ADD,  11'h000, 16'h0002, 0, 11'h411, 16'hBEF1, 0);
        vt[20] = mk(SUB,  11'h001, 16'hBEF1, 0, 11'h412, 16'h0000, 0);
        vt[21] = mk(SUB,  11'h002, 16'h0001, 0, 11'h413, 16'hFFFF, 0);
        vt[22] = mk(BLT,  11'h420, 16'h0000, 0, 11'h420, 16'hFFFF, 0);
        vt[23] = mk(NOP,  11'h000, 16'h0000, 0, 11'h421, 16'hFFFF, 0);
        vt[24] = mk(XOR,  11'h003, 16'h0003, 0, 11'h422, X_ACC,    0);
        vt[25] = mk(JMP,  11'h00A, 16'h0000, 0, 11'h00A, X_ACC,    0);
        vt[26] = mk(HLT,  11'h000, 16'h0000, 0, 11'h00A, X_ACC,    1);
        vt[27] = mk(STO,  11'h005, 16'h0000, 0, 11'h00A, X_ACC,    1);
        vt[28] = mk(LDI,  11'h001, 16'h0000, 0, 11'h00A, X_ACC,    1);

        // Reset with HLT on the bus, then STO during reset must not strobe.
        bus.instruction_in = ins(HLT, 11'h000);
        bus.data_in        = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.pc",   32'(bus.instruction_address_out), 32'h0);
        chk("rst.acc",  32'(bus.data_out), 32'h0);
        chk("rst.wr",   32'(bus.data_wr_out), 32'h0);
        chk("rst.halt", 32'(bus.halted_out), 32'h0);
        @(negedge clk);
        bus.instruction_in = ins(STO, 11'h005);
        #1;
        chk("rst.sto_wr", 32'(bus.data_wr_out), 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 29; i++) apply(vt[i], $sformatf("v%0d", i));

        // One reset edge releases the halt.
        rst_n = 1'b0;
        bus.instruction_in = ins(STO, 11'h005);
        #1;
        chk("hrst.wr", 32'(bus.data_wr_out), 32'h0);
        @(posedge clk);
        #1;
        chk("hrst.pc",   32'(bus.instruction_address_out), 32'h0);
        chk("hrst.acc",  32'(bus.data_out), 32'h0);
        chk("hrst.halt", 32'(bus.halted_out), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        apply(mk(JMP, 11'h7FF, 16'h0000, 0, 11'h7FF, 16'h0000, 0), "wrap.jmp");
        apply(mk(NOP, 11'h000, 16'h0000, 0, 11'h000, 16'h0000, 0), "wrap.nop");

`ifdef BIP3_LOGIC_EN
        apply(mk(LDI,  11'h00F, 16'h0000, 0, 11'h001, 16'h000F, 0), "lg.ldi");
        apply(mk(ANDI, 11'h0F0, 16'h0000, 0, 11'h002, 16'h0000, 0), "lg.andi");
        apply(mk(BEQ,  11'h100, 16'h0000, 0, 11'h100, 16'h0000, 0), "lg.beq");
        apply(mk(LDI,  11'h001, 16'h0000, 0, 11'h101, 16'h0001, 0), "lg.ldi1");
        apply(mk(SLL,  11'h00F, 16'h0000, 0, 11'h102, 16'h8000, 0), "lg.sll");
        apply(mk(BLT,  11'h200, 16'h0000, 0, 11'h200, 16'h8000, 0), "lg.blt");
        apply(mk(SRL,  11'h00F, 16'h0000, 0, 11'h201, 16'h0001, 0), "lg.srl");
        apply(mk(BGT,  11'h300, 16'h0000, 0, 11'h300, 16'h0001, 0), "lg.bgt");
        apply(mk(NOT,  11'h000, 16'h0000, 0, 11'h301, 16'hFFFE, 0), "lg.not");
        apply(mk(ORI,  11'h001, 16'h0000, 0, 11'h302, 16'hFFFF, 0), "lg.ori");
        apply(mk(XORI, 11'h7FF, 16'h0000, 0, 11'h303, 16'h0000, 0), "lg.xori");
        apply(mk(BEQ,  11'h010, 16'h0000, 0, 11'h010, 16'h0000, 0), "lg.beq2");
        apply(mk(OR,   11'h000, 16'h00F0, 0, 11'h011, 16'h00F0, 0), "lg.or");
        apply(mk(XOR,  11'h000, 16'h00FF, 0, 11'h012, 16'h000F, 0), "lg.xor");
        apply(mk(AND,  11'h000, 16'h0003, 0, 11'h013, 16'h0003, 0), "lg.and");
`else
        apply(mk(LDI,  11'h001, 16'h0000, 0, 11'h001, 16'h0001, 0), "nl.ldi");
        apply(mk(SLL,  11'h00F, 16'h0000, 0, 11'h002, 16'h0001, 0), "nl.sll");
        apply(mk(NOT,  11'h000, 16'h0000, 0, 11'h003, 16'h0001, 0), "nl.not");
        apply(mk(BNE,  11'h050, 16'h0000, 0, 11'h050, 16'h0001, 0), "nl.bne");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
